soc_mem_arbiter: RTL and testbench

//  Two-master arbiter in front of a single SoC memory slave (block-memory controller).
//  M0 is the instruction fetch port and M1 the data port; both share one memory over the SoC memory protocol.

---
 rtl/soc_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_soc_mem_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/soc_mem_arbiter.sv
// soc_mem_arbiter: two-master round-robin arbiter in front of one memory slave.
// M0 (instruction fetch) and M1 (data) share the slave; a master may take up to
// MAX_BURST completed transactions while the other waits, and every hand-over
// passes through one idle bus cycle so the slave controller restarts cleanly.
module soc_mem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        res,
    // M0: instruction fetch master
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic        m0_write_en,
    input  logic [3:0]  m0_byte_en,
    input  logic [31:0] m0_write_data,
    output logic [31:0] m0_read_data,
    output logic        m0_valid,
    // M1: data master
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic        m1_write_en,
    input  logic [3:0]  m1_byte_en,
    input  logic [31:0] m1_write_data,
    output logic [31:0] m1_read_data,
    output logic        m1_valid,
    // S: memory controller
    output logic        s_req,
    output logic [31:0] s_addr,
    output logic        s_write_en,
    output logic [3:0]  s_byte_en,
    output logic [31:0] s_write_data,
    input  logic [31:0] s_read_data,
    input  logic        s_valid,
    // status
    output logic [1:0]  owner
);

    localparam int            CW    = $clog2(MAX_BURST + 1);
    localparam logic [CW:0]   MAX_B = MAX_BURST[CW:0];

    // State encoding doubles as the owner status code.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic            last_q, last_d;          // 0: M0 granted last, 1: M1 granted last
    logic [CW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [CW:0]     cnt_inc;
    logic            cap_hit;
    logic            done;

    // Completion of the granted master's transaction and burst-cap detection.
    always_comb begin
        cnt_inc = {1'b0, burst_cnt_q} + {{CW{1'b0}}, 1'b1};
        cap_hit = (cnt_inc >= MAX_B);
        done    = ((state_q == GNT0) && m0_req && s_valid) ||
                  ((state_q == GNT1) && m1_req && s_valid);
    end

    // Next-state: round-robin pick from IDLE, release on drop or forced hand-over.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_req && m1_req) state_d = last_q ? GNT0 : GNT1;
                else if (m0_req)      state_d = GNT0;
                else if (m1_req)      state_d = GNT1;
            end
            GNT0: begin
                if (!m0_req)                           state_d = IDLE;
                else if (s_valid && m1_req && cap_hit) state_d = IDLE;
            end
            GNT1: begin
                if (!m1_req)                           state_d = IDLE;
                else if (s_valid && m0_req && cap_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Round-robin history and burst counter updates.
    always_comb begin
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        if ((state_q == IDLE) && (state_d != IDLE)) begin
            last_d      = (state_d == GNT1);
            burst_cnt_d = '0;
        end else if (done) begin
            burst_cnt_d = cap_hit ? MAX_B[CW-1:0] : cnt_inc[CW-1:0];
        end
    end

    // State registers; reset drops the bus at once and favours M0 on the first tie.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    // Output mux: route the granted master to the slave, return valid to it only.
    always_comb begin
        s_req        = 1'b0;
        s_addr       = '0;
        s_write_en   = 1'b0;
        s_byte_en    = '0;
        s_write_data = '0;
        m0_valid     = 1'b0;
        m1_valid     = 1'b0;
        owner        = state_q;
        case (state_q)
            GNT0: begin
                s_req        = m0_req;
                s_addr       = m0_addr;
                s_write_en   = m0_write_en;
                s_byte_en    = m0_byte_en;
                s_write_data = m0_write_data;
                m0_valid     = s_valid;
            end
            GNT1: begin
                s_req        = m1_req;
                s_addr       = m1_addr;
                s_write_en   = m1_write_en;
                s_byte_en    = m1_byte_en;
                s_write_data = m1_write_data;
                m1_valid     = s_valid;
            end
            default: ;
        endcase
    end

    // Read data is only driven toward the master whose transaction is completing.
    assign m0_read_data = m0_valid ? s_read_data : 'z;
    assign m1_read_data = m1_valid ? s_read_data : 'z;

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// tb_soc_mem_arbiter: directed bench for soc_mem_arbiter with a small
// block-RAM slave model (valid on the third cycle of a held request).
module tb_soc_mem_arbiter;

    logic        clk;
    logic        res;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m1_addr, m0_write_data, m1_write_data;
    logic        m0_write_en, m1_write_en;
    logic [3:0]  m0_byte_en, m1_byte_en;
    wire  [31:0] m0_read_data, m1_read_data;
    logic        m0_valid, m1_valid;
    logic        s_req, s_write_en, s_valid;
    logic [31:0] s_addr, s_write_data, s_read_data;
    logic [3:0]  s_byte_en;
    logic [1:0]  owner;

    soc_mem_arbiter #(.MAX_BURST(4)) dut (
        .clk(clk), .res(res),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_write_en(m0_write_en),
        .m0_byte_en(m0_byte_en), .m0_write_data(m0_write_data),
        .m0_read_data(m0_read_data), .m0_valid(m0_valid),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_write_en(m1_write_en),
        .m1_byte_en(m1_byte_en), .m1_write_data(m1_write_data),
        .m1_read_data(m1_read_data), .m1_valid(m1_valid),
        .s_req(s_req), .s_addr(s_addr), .s_write_en(s_write_en),
        .s_byte_en(s_byte_en), .s_write_data(s_write_data),
        .s_read_data(s_read_data), .s_valid(s_valid),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: 1024-word RAM, word i preloaded with 0xA0000000 + i.
    logic [31:0] mem [0:1023];
    logic [1:0]  sl_cnt;
    logic        preload;
    assign s_valid     = s_req && (sl_cnt == 2'd2);
    assign s_read_data = mem[s_addr[11:2]];

    always @(posedge clk or negedge res) begin
        if (!res)                  sl_cnt <= 2'd0;
        else if (s_req && !s_valid) sl_cnt <= sl_cnt + 2'd1;
        else                       sl_cnt <= 2'd0;
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        end else if (res && s_valid && s_write_en) begin
            for (int b = 0; b < 4; b++)
                if (s_byte_en[b]) mem[s_addr[11:2]][8*b +: 8] <= s_write_data[8*b +: 8];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Window driver state: start/drop cycles and transaction counts per master.
    int m0_start, m1_start, m0_drop, m1_drop, m0_left, m1_left;
    logic [1:0]  own_log  [0:63];
    logic        sreq_log [0:63];
    logic [31:0] cnt_log  [0:63];
    int          c0 [0:15];
    int          c1 [0:15];
    logic [31:0] r0 [0:15];
    logic [31:0] r1 [0:15];
    int          n0, n1;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Runs n cycles from the current posedge+1, logging bus status and completions.
    task automatic run_win(input int n);
        logic d0, d1;
        n0 = 0; n1 = 0;
        for (int k = 0; k < 16; k++) begin c0[k] = -1; c1[k] = -1; r0[k] = '0; r1[k] = '0; end
        for (int c = 0; c < n; c++) begin
            if (c == m0_start && m0_left > 0) m0_req = 1'b1;
            if (c == m1_start && m1_left > 0) m1_req = 1'b1;
            if (c == m0_drop) m0_req = 1'b0;
            if (c == m1_drop) m1_req = 1'b0;
            @(negedge clk);
            own_log[c]  = owner;
            sreq_log[c] = s_req;
            cnt_log[c]  = 32'(dut.burst_cnt_q);
            d0 = m0_valid;
            d1 = m1_valid;
            if (d0 && n0 < 16) begin c0[n0] = c; r0[n0] = m0_read_data; n0++; end
            if (d1 && n1 < 16) begin c1[n1] = c; r1[n1] = m1_read_data; n1++; end
            tick();
            if (d0) begin m0_left--; m0_addr += 32'd4; if (m0_left == 0) m0_req = 1'b0; end
            if (d1) begin m1_left--; m1_addr += 32'd4; if (m1_left == 0) m1_req = 1'b0; end
        end
    endtask

    task automatic clear_plan();
        m0_start = -1; m1_start = -1; m0_drop = -1; m1_drop = -1;
        m0_left = 0; m1_left = 0;
        m0_write_en = 1'b0; m1_write_en = 1'b0;
    endtask

    int exp3 [0:9] = '{3, 6, 9, 12, 21, 24, 27, 30, 33, 36};

    initial begin
        res = 1'b0; preload = 1'b1;
        m0_req = 1'b0; m1_req = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_write_data = '0; m1_write_data = '0;
        m0_write_en = 1'b0; m1_write_en = 1'b0;
        m0_byte_en = 4'hF; m1_byte_en = 4'hF;
        clear_plan();
        tick();
        preload = 1'b0;
        @(negedge clk);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_sreq", 32'(s_req), 32'h0);
        chk("rst_m0valid", 32'(m0_valid), 32'h0);
        tick();
        res = 1'b1;

        // 1: lone M0 read of 0x010
        clear_plan(); m0_start = 0; m0_left = 1; m0_addr = 32'h010;
        run_win(6);
        chk("t1_owner_c0", 32'(own_log[0]), 32'h0);
        chk("t1_sreq_c0", 32'(sreq_log[0]), 32'h0);
        chk("t1_owner_c1", 32'(own_log[1]), 32'h1);
        chk("t1_sreq_c1", 32'(sreq_log[1]), 32'h1);
        chk("t1_m0_cnt", n0, 1);
        chk("t1_m0_cycle", c0[0], 3);
        chk("t1_m0_data", r0[0], 32'hA000_0004);
        chk("t1_m1_cnt", n1, 0);
        chk("t1_owner_end", 32'(own_log[5]), 32'h0);

        // 2: simultaneous requests after reset, M0 first, one gap, then M1
        res = 1'b0; tick(); res = 1'b1;
        clear_plan(); m0_start = 0; m0_left = 1; m0_addr = 32'h020;
        m1_start = 0; m1_left = 1; m1_addr = 32'h030;
        run_win(12);
        chk("t2_owner_c1", 32'(own_log[1]), 32'h1);
        chk("t2_m0_cycle", c0[0], 3);
        chk("t2_m0_data", r0[0], 32'hA000_0008);
        chk("t2_sreq_c4", 32'(sreq_log[4]), 32'h0);
        chk("t2_gap_owner", 32'(own_log[5]), 32'h0);
        chk("t2_gap_sreq", 32'(sreq_log[5]), 32'h0);
        chk("t2_owner_c6", 32'(own_log[6]), 32'h2);
        chk("t2_m1_cycle", c1[0], 8);
        chk("t2_m1_data", r1[0], 32'hA000_000C);
        chk("t2_m0_cnt", n0, 1);

        // 3: M0 streams 10 reads while M1 waits; burst cap of 4 forces a hand-over
        clear_plan(); m0_start = 0; m0_left = 10; m0_addr = 32'h040;
        m1_start = 0; m1_left = 1; m1_addr = 32'h080;
        run_win(40);
        chk("t3_m0_cnt", n0, 10);
        for (int k = 0; k < 10; k++) chk($sformatf("t3_m0_cycle%0d", k), c0[k], exp3[k]);
        chk("t3_m0_data9", r0[9], 32'hA000_0019);
        chk("t3_m1_cnt", n1, 1);
        chk("t3_m1_cycle", c1[0], 16);
        chk("t3_m1_data", r1[0], 32'hA000_0020);
        chk("t3_gap1_owner", 32'(own_log[13]), 32'h0);
        chk("t3_gap1_sreq", 32'(sreq_log[13]), 32'h0);
        chk("t3_owner_c14", 32'(own_log[14]), 32'h2);
        chk("t3_gap2_owner", 32'(own_log[18]), 32'h0);
        chk("t3_owner_c19", 32'(own_log[19]), 32'h1);

        // 4: M0 then M1 write the same word; last write wins
        clear_plan(); m0_start = 0; m0_left = 1; m0_addr = 32'h100;
        m0_write_en = 1'b1; m0_write_data = 32'hDEAD_BEEF;
        m1_start = 1; m1_left = 1; m1_addr = 32'h100;
        m1_write_en = 1'b1; m1_write_data = 32'h1234_5678;
        run_win(12);
        chk("t4_m0_cycle", c0[0], 3);
        chk("t4_gap_owner", 32'(own_log[5]), 32'h0);
        chk("t4_gap_sreq", 32'(sreq_log[5]), 32'h0);
        chk("t4_m1_cycle", c1[0], 8);
        chk("t4_ram", mem[32'h40], 32'h1234_5678);
        clear_plan(); m0_start = 0; m0_left = 1; m0_addr = 32'h100;
        run_win(6);
        chk("t4_readback", r0[0], 32'h1234_5678);

        // 5: reset while an M1 write is pending
        clear_plan();
        m1_addr = 32'h200; m1_write_en = 1'b1; m1_write_data = 32'hCAFE_F00D; m1_req = 1'b1;
        tick();
        @(negedge clk);
        chk("t5_owner_gnt1", 32'(owner), 32'h2);
        tick();
        m0_addr = 32'h010; m0_write_en = 1'b0; m0_req = 1'b1;
        #2 res = 1'b0;
        #1;
        chk("t5_rst_sreq", 32'(s_req), 32'h0);
        chk("t5_rst_owner", 32'(owner), 32'h0);
        chk("t5_rst_m1valid", 32'(m1_valid), 32'h0);
        tick();
        res = 1'b1;
        @(negedge clk);
        chk("t5_owner_idle", 32'(owner), 32'h0);
        tick();
        @(negedge clk);
        chk("t5_owner_m0", 32'(owner), 32'h1);
        chk("t5_saddr", s_addr, 32'h010);
        chk("t5_ram", mem[32'h80], 32'hA000_0080);
        m0_req = 1'b0; m1_req = 1'b0; m1_write_en = 1'b0;
        tick(); tick(); tick();

        // 6: M1 abandons its request while M0 waits
        clear_plan(); m1_start = 0; m1_left = 1; m1_addr = 32'h0C0; m1_drop = 3;
        m0_start = 1; m0_left = 1; m0_addr = 32'h010;
        run_win(10);
        chk("t6_owner_c1", 32'(own_log[1]), 32'h2);
        chk("t6_owner_c3", 32'(own_log[3]), 32'h2);
        chk("t6_sreq_c3", 32'(sreq_log[3]), 32'h0);
        chk("t6_owner_c4", 32'(own_log[4]), 32'h0);
        chk("t6_burst_c4", cnt_log[4], 32'h0);
        chk("t6_owner_c5", 32'(own_log[5]), 32'h1);
        chk("t6_m1_cnt", n1, 0);
        chk("t6_m0_cycle", c0[0], 7);
        chk("t6_m0_data", r0[0], 32'hA000_0004);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
